// File: rtl/ipd_pkg.sv
// Shared types and helpers for the I-PD sequential controller.
// Holds the FSM state encoding and a generic signed saturation helper
// used for both the integrator clamp and the output clamp.
package ipd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMulI,
        StMulP,
        StMulD,
        StOut
    } ipd_state_e;

    // Largest positive value of a w-bit signed quantity.
    function automatic logic signed [63:0] sat_hi(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Most negative limit; sym=1 gives the symmetric range +/-(2^(w-1)-1).
    function automatic logic signed [63:0] sat_lo(input int unsigned w, input logic sym);
        return sym ? -sat_hi(w) : -sat_hi(w) - 64'sd1;
    endfunction

    // Clamp v into the w-bit signed range.
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v,
                                                    input int unsigned w,
                                                    input logic sym);
        if (v > sat_hi(w)) begin
            return sat_hi(w);
        end else if (v < sat_lo(w, sym)) begin
            return sat_lo(w, sym);
        end
        return v;
    endfunction

endpackage

// File: rtl/ipd_mul.sv
// Registered signed multiplier, one cycle from operands to product.
// Shared by the integral, proportional and derivative product stages.
module ipd_mul #(
    parameter int unsigned A_W = 7,
    parameter int unsigned B_W = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [A_W-1:0]      a_i,
    input  logic signed [B_W-1:0]      b_i,
    output logic signed [A_W+B_W-1:0]  p_o
);

    // Full-width signed product, registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_o <= '0;
        end else begin
            p_o <= a_i * b_i;
        end
    end

endmodule

// File: rtl/ipd_seq_controller.sv
// Sequential I-PD servo controller: u = ik_next - KP*yk - KD*(yk - yk_prev).
// One shared multiplier is stepped through KI*ek, KP*yk and KD*dy by the FSM.
// Optional macro IPD_ANTIWINDUP_EN freezes the integrator while the output is
// saturated and the error would drive it further into the same limit.
module ipd_seq_controller
    import ipd_pkg::*;
#(
    parameter int unsigned Y_W   = 9,
    parameter int unsigned K_W   = 7,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned OUT_W = 19,
    parameter int          KP    = 36,
    parameter int          KI    = 1,
    parameter int          KD    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    clr,
    input  logic signed [Y_W-1:0]   rk,
    input  logic signed [Y_W-1:0]   yk,
    output logic                    busy,
    output logic                    done,
    output logic signed [OUT_W-1:0] u,
    output logic                    sat
);

    localparam int unsigned E_W = Y_W + 1;
    localparam int unsigned P_W = K_W + E_W;
    localparam int unsigned U_W = ACC_W + 2;

    ipd_state_e              state_q;
    logic signed [Y_W-1:0]   yk_q, yk_prev_q;
    logic signed [E_W-1:0]   ek_q;
    logic signed [ACC_W-1:0] ik_q, ik_nx_q, pp_q;
    logic signed [OUT_W-1:0] u_q;
    logic                    sat_q, busy_q, done_q, clr_pend_q;

    logic signed [K_W-1:0]   mul_a;
    logic signed [E_W-1:0]   mul_b;
    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext, ik_next;
    logic signed [E_W-1:0]   dy;
    logic signed [ACC_W:0]   ik_sum;
    logic signed [U_W-1:0]   u_full;
    logic signed [OUT_W-1:0] u_next;
    logic                    u_clamped;

    ipd_mul #(
        .A_W (K_W),
        .B_W (E_W)
    ) u_mul (
        .clk (clk),
        .rst (rst),
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (prod)
    );

    // Steer gain/operand pair into the shared multiplier for the current stage.
    always_comb begin
        dy    = E_W'(yk_q) - E_W'(yk_prev_q);
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            StMulI: begin
                mul_a = K_W'(KI);
                mul_b = ek_q;
            end
            StMulP: begin
                mul_a = K_W'(KP);
                mul_b = E_W'(yk_q);
            end
            StMulD: begin
                mul_a = K_W'(KD);
                mul_b = dy;
            end
            default: ;
        endcase
    end

    // Integrator update and output sum; prod holds the product of the previous stage.
    always_comb begin
        prod_ext = ACC_W'(prod);
        ik_sum   = (ACC_W + 1)'(ik_q) + (ACC_W + 1)'(prod_ext);
`ifdef IPD_ANTIWINDUP_EN
        // prod is KI*ek here; freeze when it pushes further into the held limit.
        if (sat_q && ((prod > 0 && !u_q[OUT_W-1]) || (prod < 0 && u_q[OUT_W-1]))) begin
            ik_next = ik_q;
        end else begin
            ik_next = ACC_W'(sat_clip(64'(ik_sum), ACC_W, 1'b1));
        end
`else
        ik_next = ACC_W'(sat_clip(64'(ik_sum), ACC_W, 1'b1));
`endif
        u_full    = U_W'(ik_nx_q) - U_W'(pp_q) - U_W'(prod_ext);
        u_next    = OUT_W'(sat_clip(64'(u_full), OUT_W, 1'b0));
        u_clamped = (U_W'(u_next) != u_full);
    end

    // Control FSM with registered outputs and state writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            yk_q       <= '0;
            yk_prev_q  <= '0;
            ek_q       <= '0;
            ik_q       <= '0;
            ik_nx_q    <= '0;
            pp_q       <= '0;
            u_q        <= '0;
            sat_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            // A clear seen at any busy cycle is applied at writeback.
            clr_pend_q <= clr_pend_q | clr;
            case (state_q)
                StIdle: begin
                    clr_pend_q <= 1'b0;
                    if (clr) begin
                        ik_q      <= '0;
                        yk_prev_q <= '0;
                    end else if (start) begin
                        yk_q    <= yk;
                        ek_q    <= E_W'(rk) - E_W'(yk);
                        busy_q  <= 1'b1;
                        state_q <= StMulI;
                    end
                end
                StMulI: state_q <= StMulP;
                StMulP: begin
                    ik_nx_q <= ik_next;
                    state_q <= StMulD;
                end
                StMulD: begin
                    pp_q    <= prod_ext;
                    state_q <= StOut;
                end
                StOut: begin
                    u_q     <= u_next;
                    sat_q   <= u_clamped;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                    if (clr || clr_pend_q) begin
                        ik_q      <= '0;
                        yk_prev_q <= '0;
                    end else begin
                        ik_q      <= ik_nx_q;
                        yk_prev_q <= yk_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign u    = u_q;
    assign sat  = sat_q;

endmodule

// File: tb/tb_ipd_seq_controller.sv
// Directed bench for ipd_seq_controller: a default-width instance plus an
// OUT_W=12 instance for output saturation.
module tb_ipd_seq_controller;

    logic clk = 1'b0;
    logic rst, rst12, start, clr;
    logic signed [8:0]  rk, yk;
    logic               busy, done, sat;
    logic signed [18:0] u;
    logic               busy12, done12, sat12;
    logic signed [11:0] u12;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ipd_seq_controller dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .clr   (clr),
        .rk    (rk),
        .yk    (yk),
        .busy  (busy),
        .done  (done),
        .u     (u),
        .sat   (sat)
    );

    ipd_seq_controller #(
        .OUT_W (12)
    ) dut12 (
        .clk   (clk),
        .rst   (rst12),
        .start (start),
        .clr   (clr),
        .rk    (rk),
        .yk    (yk),
        .busy  (busy12),
        .done  (done12),
        .u     (u12),
        .sat   (sat12)
    );

    typedef struct {
        int rk;
        int yk;
        int u;
        int sat;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one start (entered #1 after a rising edge). start is held high for
    // hold extra cycles; clr pulses on loop step clr_at (-1 = none).
    task automatic run(input int r, input int y, input int hold, input int clr_at,
                       output int lat, output int busy_n, output int done_n,
                       output int done12_n);
        rk       = 9'(r);
        yk       = 9'(y);
        clr      = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = -1;
        busy_n   = 0;
        done_n   = 0;
        done12_n = 0;
        for (int c = 0; c < 12; c++) begin
            if (busy) busy_n++;
            if (done12) done12_n++;
            if (done) begin
                done_n++;
                if (lat < 0) lat = c;
            end
            start = (c < hold);
            clr   = (c == clr_at);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        clr   = 1'b0;
    endtask

    int lat, bn, dn, dn12;

    initial begin
        rst   = 1'b1;
        rst12 = 1'b1;
        start = 1'b0;
        clr   = 1'b0;
        rk    = '0;
        yk    = '0;

        vecs[0] = '{rk: 10,  yk: 0,  u: 10,   sat: 0};
        vecs[1] = '{rk: 10,  yk: 5,  u: -205, sat: 0};
        vecs[2] = '{rk: -20, yk: -8, u: 395,  sat: 0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_u", int'(u), 0);
        check("reset_sat", int'(sat), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);

        for (int i = 0; i < 3; i++) begin
            run(vecs[i].rk, vecs[i].yk, 0, -1, lat, bn, dn, dn12);
            check($sformatf("vec%0d_u", i), int'(u), vecs[i].u);
            check($sformatf("vec%0d_sat", i), int'(sat), vecs[i].sat);
            check($sformatf("vec%0d_latency", i), lat, 4);
            check($sformatf("vec%0d_dones", i), dn, 1);
            check($sformatf("vec%0d_busy_cycles", i), bn, 4);
        end

        // start held through the busy window: ignored, one done only.
        run(0, 5, 3, -1, lat, bn, dn, dn12);
        check("busy_start_dones", dn, 1);
        check("busy_start_busy_cycles", bn, 4);
        check("busy_start_latency", lat, 4);
        check("busy_start_u", int'(u), -286);

        // clr with start in IDLE: no update, state cleared.
        clr   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        clr   = 1'b0;
        start = 1'b0;
        dn = 0;
        bn = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) dn++;
            if (busy) bn++;
            @(posedge clk);
            #1;
        end
        check("clr_start_dones", dn, 0);
        check("clr_start_busy", bn, 0);
        check("clr_start_u_held", int'(u), -286);
        run(3, 0, 0, -1, lat, bn, dn, dn12);
        check("after_clr_u", int'(u), 3);

        // clr mid-computation: result uses old ik, then ik/yk_prev zeroed.
        run(10, 0, 0, 1, lat, bn, dn, dn12);
        check("clr_busy_u", int'(u), 13);
        check("clr_busy_dones", dn, 1);
        run(2, 0, 0, -1, lat, bn, dn, dn12);
        check("clr_busy_next_u", int'(u), 2);

        // Reset while in MUL_P aborts the update.
        rk    = 9'sd50;
        yk    = 9'sd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_u", int'(u), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        dn = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) dn++;
            if (c == 2) rst = 1'b0;
            @(posedge clk);
            #1;
        end
        check("midrst_dones", dn, 0);
        run(4, 0, 0, -1, lat, bn, dn, dn12);
        check("midrst_next_u", int'(u), 4);

        // Output saturation on the narrow instance, fresh from reset.
        rst12 = 1'b0;
        run(0, -100, 0, -1, lat, bn, dn, dn12);
        check("sat_pos_u12", int'(u12), 2047);
        check("sat_pos_sat12", int'(sat12), 1);
        check("sat_pos_done12", dn12, 1);
        check("sat_pos_u", int'(u), 4504);
        check("sat_pos_sat", int'(sat), 0);

        run(0, 100, 0, -1, lat, bn, dn, dn12);
        check("sat_neg_u12", int'(u12), -2048);
        check("sat_neg_sat12", int'(sat12), 1);
        check("sat_neg_u", int'(u), -5196);
        check("sat_neg_busy12", int'(busy12), 0);

`ifdef IPD_ANTIWINDUP_EN
        // Leaving the negative limit integrates normally (ik=100), then a
        // positive error at the positive limit must leave ik at 100.
        run(0, -100, 0, -1, lat, bn, dn, dn12);
        check("aw_pos_u12", int'(u12), 2047);
        run(10, -100, 0, -1, lat, bn, dn, dn12);
        check("aw_hold_u12", int'(u12), 2047);
        check("aw_hold_sat12", int'(sat12), 1);
        run(0, 0, 0, -1, lat, bn, dn, dn12);
        check("aw_frozen_ik_u12", int'(u12), -700);
        check("aw_frozen_ik_sat12", int'(sat12), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ipd_seq_controller.md
Name: ipd_seq_controller

Overview:
- Parametrised successor of the single-cycle I-PD output stage: full I-PD servo law computed in-block from reference rk and measurement yk.
- Owns integral state ik, previous measurement yk_prev and the derivative term; nothing is computed upstream.
- One shared signed multiplier, sequenced by an FSM with start/busy/done handshake. Output is saturated to OUT_W with a saturation flag.
- Sits between the sample timer / encoder front end and the PWM generator.

Parameters:
- Y_W, 9, signed width of rk and yk.
- K_W, 7, signed width of gain constants.
- ACC_W, 24, signed internal accumulator width (ik, products, sums).
- OUT_W, 19, signed width of output u.
- KP, 36, proportional gain applied to yk.
- KI, 1, integral gain applied to ek.
- KD, 8, derivative gain applied to (yk - yk_prev).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request one control update; sampled only in IDLE.
- clr  in  1  synchronous clear of ik and yk_prev.
- rk  in  Y_W  signed reference, captured on accepted start.
- yk  in  Y_W  signed measurement, captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when u is updated.
- u  out  OUT_W  signed control action; held between updates.
- sat  out  1  high when the last u was clamped; updated together with u.

Behaviour:
- Reset (asynchronous, rst=1): state IDLE; u=0, sat=0, busy=0, done=0, ik=0, yk_prev=0, all operand registers 0.
- Reset mid-operation aborts the computation. No done pulse is produced, and the next update starts from the zeroed state.
- FSM states and transitions:
  - IDLE: start=1 and clr=0 -> capture rk, yk; compute ek = rk - yk (Y_W+1 bits); go to MUL_I.
  - MUL_I: multiplier computes KI*ek -> MUL_P.
  - MUL_P: ik_next = sat_ACC(ik + KI*ek); multiplier computes KP*yk -> MUL_D.
  - MUL_D: multiplier computes KD*(yk - yk_prev) -> OUT.
  - OUT: u_full = ik_next - KP*yk - dk, formed in ACC_W+2 bits; u = sat_OUT(u_full); sat set accordingly; ik = ik_next; yk_prev = yk; done=1 -> IDLE.
- Latency: done asserts exactly 4 cycles after the start edge (1 + 3 stage cycles). Throughput is one update per 5 cycles.
- start while busy is ignored (no queueing). start held high re-triggers on the cycle after done.
- clr in IDLE: ik=0, yk_prev=0, u unchanged.
- clr while busy: the computation completes using the pre-clear ik, then ik and yk_prev are forced to 0 in the OUT cycle. clr takes priority over the OUT-state writeback.
- clr and start in the same IDLE cycle: clr executes, start is ignored.
- Products are full width, sign-extended to ACC_W.
- sat_ACC clamps to +/-(2^(ACC_W-1)-1); ik never wraps.
- sat_OUT clamps to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1].
- Sum order is fixed as written; no rounding or shifting.

Optional Feature:
- Macro: IPD_ANTIWINDUP_EN.
- Defined: conditional integration. If the previous u was saturated (sat=1) and sign(ek) would push u further into the same limit, ik_next = ik (integral frozen). Otherwise integration proceeds normally.
- Undefined: ik always integrates, bounded only by sat_ACC.

Decomposition:
- Package ipd_pkg: FSM state enum (IDLE, MUL_I, MUL_P, MUL_D, OUT), saturation limit constants derived from ACC_W/OUT_W, and a sat() function.
- Sub-module ipd_mul: registered signed K_W x (Y_W+1) multiplier with 1-cycle latency, shared across the three product stages.

Test Plan:
- Reset then start with rk=10, yk=0 -> done at cycle 4; u=10, sat=0, ik=10.
- Follow-up start with rk=10, yk=5 -> ek=5, ik=15, dk=40, u=15-180-40=-205.
- With OUT_W=12, after reset: start with rk=0, yk=-100 -> u_full=100+3600+800=4500, so u=2047 and sat=1.
- start pulsed at cycles 1-3 after an accepted start -> ignored; exactly one done; busy high for 4 cycles.
- clr and start together in IDLE -> no done; ik=0 and yk_prev=0. Then start with rk=3, yk=0 -> u=3.
- rst asserted in MUL_P -> immediate IDLE, u=0, no done. With IPD_ANTIWINDUP_EN and sat=1 at the positive limit plus positive ek -> ik unchanged across the update.
